// File: rtl/instr_fetch_seq_if.sv
// Fetch sequencer bus: instruction memory port, branch/halt
// inputs from control, and the presented pc/instr/valid bundle.
interface instr_fetch_seq_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_en;
    logic [PC_W-1:0]    branch_target;
    logic               halt;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;

    modport master (
        output imem_addr, pc, instr, instr_valid,
        input  imem_rdata, branch_en, branch_target, halt
    );

    modport slave (
        input  imem_addr, pc, instr, instr_valid,
        output imem_rdata, branch_en, branch_target, halt
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: PC, sync imem read, debounced step / run tick.
// Ports: clk, rst (sync, active-low), run, step_n, bus (master), busy, halted.
module instr_fetch_seq #(
    parameter int PC_W       = 8,
    parameter int INSTR_W    = 32,
    parameter int DEB_CYCLES = 500000,
    parameter int RUN_DIV    = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_n,
    instr_fetch_seq_if.master bus,
    output logic              busy,
    output logic              halted
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, EXEC, HALTED
    } state_t;

    state_t state_q, state_d;

    logic             step_meta, step_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;
    logic             deb_done;
    logic             press;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             adv;

    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_meta <= 1'b1;
            step_sync <= 1'b1;
        end else begin
            step_meta <= step_n;
            step_sync <= step_meta;
        end
    end

    // Counter runs only while the synced level differs from the
    // accepted level; any return to it restarts the count.
    assign deb_done = (step_sync != deb_level) &&
                      (deb_cnt == DEB_W'(DEB_CYCLES - 1));
    assign press    = deb_done && deb_level;

    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b1;
        end else if (step_sync == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_done) begin
            deb_cnt   <= '0;
            deb_level <= step_sync;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(RUN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign adv = run ? tick : press;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (adv) state_d = FETCH;
            FETCH:   state_d = LATCH;
            LATCH:   state_d = EXEC;
            EXEC:    state_d = bus.halt ? HALTED : IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        unique case (1'b1)
            state_q == HALTED: halted = 1'b1;
            state_q == FETCH,
            state_q == LATCH,
            state_q == EXEC:   busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == LATCH);
            if (state_q == LATCH) begin
                instr_q <= bus.imem_rdata;
            end
            if (state_q == EXEC && !bus.halt) begin
                if (bus.branch_en) begin
                    pc_q <= bus.branch_target;
                end else begin
                    pc_q <= pc_q + PC_W'(1);
                end
            end
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a 1-cycle ROM[i] = A000_0000+i.
// Ports: none; drives clk, rst, run, step_n and the slave side of the bus.
module tb_instr_fetch_seq;
    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic run    = 1'b0;
    logic step_n = 1'b1;
    logic busy, halted;

    int tests  = 0;
    int fails  = 0;
    int vcount = 0;
    int ccount = 0;
    int vlast  = 0;
    int vperiod = 0;
    int c0;
    logic [31:0] vinstr = '0;

    instr_fetch_seq_if #(.PC_W(8), .INSTR_W(32)) bus();

    instr_fetch_seq #(
        .PC_W(8), .INSTR_W(32), .DEB_CYCLES(4), .RUN_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step_n(step_n),
        .bus(bus), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.imem_rdata <= 32'hA000_0000 + {24'h0, bus.imem_addr};

    always @(posedge clk) begin
        ccount <= ccount + 1;
        if (bus.instr_valid === 1'b1) begin
            vcount  <= vcount + 1;
            vinstr  <= bus.instr;
            vperiod <= ccount - vlast;
            vlast   <= ccount;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (bus.instr_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic release_btn();
        step_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.branch_en     = 1'b0;
        bus.branch_target = 8'h00;
        bus.halt          = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rst               = 1'b0;
            run               = 1'($urandom);
            step_n            = 1'($urandom);
            bus.branch_en     = 1'($urandom);
            bus.halt          = 1'($urandom);
            bus.branch_target = 8'($urandom);
            @(negedge clk);
        end
        run = 1'b0; step_n = 1'b1;
        bus.branch_en = 1'b0; bus.halt = 1'b0;
        bus.branch_target = 8'h00;
        rst = 1'b1;
        chk("rst_pc",     32'(bus.pc), 32'd0);
        chk("rst_instr",  bus.instr, 32'd0);
        chk("rst_valid",  32'(bus.instr_valid), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // 2-cycle glitch must not fetch
        c0 = vcount;
        step_n = 1'b0;
        repeat (2) @(negedge clk);
        step_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_count", 32'(vcount - c0), 32'd0);
        chk("glitch_pc",    32'(bus.pc), 32'd0);

        // long press: exactly one instruction
        c0 = vcount;
        step_n = 1'b0;
        wait_valid("p1_valid", 20);
        chk("p1_instr",  bus.instr, 32'hA000_0000);
        chk("p1_pc_exec", 32'(bus.pc), 32'd0);
        chk("p1_busy",   32'(busy), 32'd1);
        @(negedge clk);
        chk("p1_pc_after", 32'(bus.pc), 32'd1);
        chk("p1_valid_one", 32'(bus.instr_valid), 32'd0);
        repeat (12) @(negedge clk);
        release_btn();
        chk("p1_once", 32'(vcount - c0), 32'd1);

        c0 = vcount;
        step_n = 1'b0;
        wait_valid("p2_valid", 20);
        chk("p2_instr", bus.instr, 32'hA000_0001);
        @(negedge clk);
        chk("p2_pc_after", 32'(bus.pc), 32'd2);
        release_btn();
        chk("p2_once", 32'(vcount - c0), 32'd1);

        // run mode with the button held: ticks only
        c0 = vcount;
        run = 1'b1;
        step_n = 1'b0;
        for (int n = 0; n < 60 && vcount < c0 + 3; n++)
            @(negedge clk);
        chk("run_pulses", 32'(vcount - c0), 32'd3);
        chk("run_period", 32'(vperiod), 32'd8);
        chk("run_instr",  vinstr, 32'hA000_0004);
        run = 1'b0;
        step_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("run_stop", 32'(vcount - c0), 32'd3);
        chk("run_pc",   32'(bus.pc), 32'd5);

        // branch taken in EXEC of ROM[5]
        bus.branch_en = 1'b1;
        bus.branch_target = 8'h40;
        step_n = 1'b0;
        wait_valid("br_valid", 20);
        chk("br_instr", bus.instr, 32'hA000_0005);
        @(negedge clk);
        chk("br_pc", 32'(bus.pc), 32'h40);
        bus.branch_en = 1'b0;
        release_btn();
        step_n = 1'b0;
        wait_valid("br_next_valid", 20);
        chk("br_next_instr", bus.instr, 32'hA000_0040);
        @(negedge clk);
        chk("br_next_pc", 32'(bus.pc), 32'h41);
        release_btn();

        // preload FE and run across the wrap
        bus.branch_en = 1'b1;
        bus.branch_target = 8'hFE;
        step_n = 1'b0;
        wait_valid("wr_set_valid", 20);
        @(negedge clk);
        bus.branch_en = 1'b0;
        chk("wr_set_pc", 32'(bus.pc), 32'hFE);
        release_btn();
        run = 1'b1;
        wait_valid("wr_fe_valid", 20);
        chk("wr_fe_instr", bus.instr, 32'hA000_00FE);
        @(negedge clk);
        wait_valid("wr_ff_valid", 20);
        chk("wr_ff_instr", bus.instr, 32'hA000_00FF);
        @(negedge clk);
        chk("wr_pc_wrap", 32'(bus.pc), 32'd0);
        wait_valid("wr_00_valid", 20);
        chk("wr_00_instr", bus.instr, 32'hA000_0000);
        run = 1'b0;
        repeat (12) @(negedge clk);
        chk("wr_pc_end", 32'(bus.pc), 32'd1);

        // halt at pc=3 wins over a concurrent branch
        bus.branch_en = 1'b1;
        bus.branch_target = 8'h03;
        step_n = 1'b0;
        wait_valid("h_set_valid", 20);
        @(negedge clk);
        bus.branch_en = 1'b0;
        chk("h_set_pc", 32'(bus.pc), 32'd3);
        release_btn();
        bus.halt = 1'b1;
        bus.branch_en = 1'b1;
        bus.branch_target = 8'h10;
        step_n = 1'b0;
        wait_valid("h_valid", 20);
        chk("h_instr", bus.instr, 32'hA000_0003);
        @(negedge clk);
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_pc",     32'(bus.pc), 32'd3);
        chk("h_busy",   32'(busy), 32'd0);
        bus.halt = 1'b0;
        bus.branch_en = 1'b0;
        step_n = 1'b1;
        c0 = vcount;
        run = 1'b1;
        repeat (45) @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_n = 1'b0;
            repeat (8) @(negedge clk);
            step_n = 1'b1;
            repeat (8) @(negedge clk);
        end
        chk("h_no_valid",   32'(vcount - c0), 32'd0);
        chk("h_still_halt", 32'(halted), 32'd1);
        chk("h_still_pc",   32'(bus.pc), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("h_rst_pc",     32'(bus.pc), 32'd0);
        chk("h_rst_halted", 32'(halted), 32'd0);
        repeat (4) @(negedge clk);

        // reset while in LATCH aborts the instruction
        step_n = 1'b0;
        for (int n = 0; n < 20 && busy !== 1'b1; n++)
            @(negedge clk);
        chk("rm_fetch_busy", 32'(busy), 32'd1);
        @(negedge clk);
        c0 = vcount;
        rst = 1'b0;
        step_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        chk("rm_valid", 32'(bus.instr_valid), 32'd0);
        chk("rm_busy",  32'(busy), 32'd0);
        chk("rm_pc",    32'(bus.pc), 32'd0);
        chk("rm_instr", bus.instr, 32'd0);
        repeat (12) @(negedge clk);
        chk("rm_no_pulse", 32'(vcount - c0), 32'd0);
        step_n = 1'b0;
        wait_valid("rm_next_valid", 20);
        chk("rm_next_instr", bus.instr, 32'hA000_0000);
        @(negedge clk);
        chk("rm_next_pc", 32'(bus.pc), 32'd1);
        release_btn();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer for the CPU v0.1 datapath. It sits directly upstream of the register file and ULA. It holds the program counter, reads the synchronous instruction memory, and presents one instruction at a time together with a one-cycle `instr_valid` strobe that qualifies register-file writes. Instructions advance either by a debounced push-button step or by a free-running tick derived from CLOCK_50, so the board can be single-stepped or run at a human-visible rate.

## Interface
Parameters:
- PC_W, 8, program counter and instruction-memory address width
- INSTR_W, 32, instruction width
- DEB_CYCLES, 500000, number of stable cycles required to accept a step_n level (10 ms at 50 MHz)
- RUN_DIV, 25000000, clock cycles between run-mode ticks; must be ≥ 4

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  reset, synchronous, active-low
- run  in  1  1 = free-run on ticks; 0 = single-step on step_n presses
- step_n  in  1  raw push-button (KEY), active-low, asynchronous to clk
- imem_addr  out  PC_W  instruction memory address; always equals pc
- imem_rdata  in  INSTR_W  instruction memory data; valid one cycle after the address is sampled
- branch_en  in  1  from control unit/ULA; sampled in EXEC
- branch_target  in  PC_W  next PC when branch_en is asserted
- halt  in  1  decoded halt from control unit; sampled in EXEC
- pc  out  PC_W  current program counter
- instr  out  INSTR_W  latched instruction
- instr_valid  out  1  one-cycle pulse (the EXEC cycle)
- busy  out  1  high in FETCH, LATCH and EXEC
- halted  out  1  high in HALTED

## Operation
- step_n input conditioning:
  - 2-FF synchronizer.
  - Debounce counter resets on every change of the synchronized level.
  - The stable level updates after DEB_CYCLES equal samples.
  - A press event is a stable-level transition from 1 to 0.
  - Press events are used only when run=0.
- Run ticks:
  - The divider counts 0..RUN_DIV-1 while run=1 and emits a tick on the terminal count.
  - The divider is held at 0 while run=0, so the first tick after switching run from 0 to 1 comes RUN_DIV cycles later.
- Advance event: a press (run=0) or a tick (run=1). Events that arrive outside IDLE are dropped and are not queued.
- FSM states: IDLE, FETCH, LATCH, EXEC, HALTED.
  - IDLE to FETCH on an advance event.
  - FETCH to LATCH unconditionally (the memory samples imem_addr).
  - LATCH to EXEC unconditionally; instr is loaded from imem_rdata.
  - EXEC to IDLE, or to HALTED if halt=1; the PC is updated here.
  - HALTED is left only by reset.
- PC update at the end of EXEC:
  - halt=1: pc unchanged. halt has priority over branch_en.
  - else branch_en=1: pc = branch_target.
  - else: pc = pc+1 modulo 2^PC_W, so 2^PC_W-1 wraps to 0.
- Changing run mid-instruction does not abort the instruction; it completes normally.

## Timing
- Reset (rst=0 at a rising edge) sets: pc=0, instr=0, instr_valid=0, busy=0, halted=0, state=IDLE, divider=0, debounce stable level=1, debounce counter=0.
- Reset overrides everything, including mid-FETCH, mid-LATCH and mid-EXEC. Any instruction in flight is aborted with no instr_valid pulse.
- Cycle-level sequence for an event seen in IDLE at cycle t:
  - t+1: FETCH.
  - t+2: LATCH.
  - t+3: EXEC; instr_valid=1 and instr holds the new value.
  - t+4: the new pc is visible; state is IDLE or HALTED.
- Latency from event to instr_valid is 3 cycles. The minimum instruction period is 4 cycles.
- instr_valid is registered and high for exactly one cycle per instruction.
- instr is stable from EXEC until the next LATCH.
- Latency from step_n to a press event is 2 synchronizer cycles plus DEB_CYCLES.

## Test plan
All tests use DEB_CYCLES=4, RUN_DIV=8, PC_W=8, INSTR_W=32, and a behavioural 1-cycle synchronous ROM with ROM[i]=32'hA000_0000+i.
- Reset: hold rst=0 for 3 cycles with random inputs, release -> pc=0, instr=0, instr_valid=0, busy=0, halted=0.
- Step and bounce, run=0:
  - Glitch step_n low for 2 cycles -> no fetch.
  - Hold step_n low for 20 cycles -> exactly one instr_valid pulse, with instr=32'hA000_0000 during the pulse, then pc=1.
  - Release and press again -> instr=32'hA000_0001, then pc=2.
- Run and wrap:
  - run=1 -> pc advances once every 8 cycles.
  - Preload pc to 8'hFE via steps or a force -> the sequence runs FE, FF, 00.
  - Presses during run=1 have no effect.
- Branch: in EXEC with ROM[5] fetched, drive branch_en=1 and branch_target=8'h40 -> pc=8'h40 on the next cycle; the next instr is 32'hA000_0040.
- Halt:
  - Assert halt=1 (with branch_en=1, target 8'h10) in EXEC at pc=3 -> halted=1 and pc stays 3.
  - 5 further ticks and presses -> no instr_valid.
  - rst=0 -> pc=0 and halted=0.
- Reset mid-operation: assert rst=0 during LATCH -> no instr_valid in the following cycle, pc=0, state IDLE; the next event fetches ROM[0].
